serial_add_arbiter: RTL and testbench

Bit-serial adder controller that time-shares a single one-bit full-adder cell between two requesters. A granted requester's operands are latched, then added LSB-first, one bit per clock, with a registered carry. The block then presents the WIDTH-bit sum and carry-out with a one-cycle `done` pulse. It sits between two client blocks and the shared full-adder datapath, and replaces two parallel ripple adders where area matters more than latency.

---
 rtl/serial_add_pkg.sv | 38 +++
 rtl/FA_B.sv | 21 ++
 rtl/serial_add_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder arbiter:
//   - state_e        : controller states (IDLE / RUN / DONE)
//   - id_t, ID0, ID1 : requester identifiers
//   - DEFAULT_WIDTH  : default operand width
//   - arb_pick()     : round-robin winner selection between two requesters
// ----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic id_t;

    localparam id_t ID0 = 1'b0;
    localparam id_t ID1 = 1'b1;

    // Round-robin pick: a lone request wins outright; on a tie the requester
    // that was not served last wins.
    function automatic id_t arb_pick(input logic r0, input logic r1, input id_t last);
        id_t win;
        if (r0 && r1) begin
            win = ~last;
        end else if (r1) begin
            win = ID1;
        end else begin
            win = ID0;
        end
        return win;
    endfunction

endpackage

// File: rtl/FA_B.sv
// ----------------------------------------------------------------------------
// FA_B
// Combinational one-bit full-adder cell shared by the serial adder.
// Ports:
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : sum bit
//   co_o     : carry out
// ----------------------------------------------------------------------------
module FA_B (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_arbiter.sv
// ----------------------------------------------------------------------------
// serial_add_arbiter
// Time-shares one full-adder cell between two requesters. A granted
// requester's operands are latched and added LSB-first, one bit per clock,
// with a registered carry; the WIDTH-bit sum and carry-out are then presented
// with a one-cycle done pulse.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req0/a0/b0/cin0       : requester 0 request and operands
//   req1/a1/b1/cin1       : requester 1 request and operands
//   gnt0, gnt1            : one-cycle grant pulses (operands captured that cycle)
//   busy                  : high from grant cycle through done cycle
//   owner                 : requester being served / last served
//   done                  : one-cycle result-valid pulse
//   sum, cout             : result, held until the next done
// ----------------------------------------------------------------------------
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    id_t                owner_q, owner_d;
    id_t                last_q, last_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 low result bits; the final bit joins them directly
    // when the sum register is loaded.
    logic [WIDTH-2:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req0_q, req1_q;

    logic               fa_s_s;
    logic               fa_co_s;
    logic [WIDTH-1:0]   res_ext_s;
    logic               elig0_s, elig1_s;
    id_t                arb_last_s;
    id_t                win_s;
    logic               any_s;

    // Shared full-adder cell on the LSBs of the operand shift registers.
    FA_B u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s_s),
        .co_o (fa_co_s)
    );

    // New sum bit enters from the MSB side of the partial result.
    assign res_ext_s = {fa_s_s, res_q};

    // Arbitration inputs. In DONE the just-served requester counts as last,
    // and only requests already present the cycle before are eligible, so a
    // request rising in the done cycle waits for the following idle cycle.
    always_comb begin
        elig0_s    = 1'b0;
        elig1_s    = 1'b0;
        arb_last_s = last_q;
        case (state_q)
            ST_IDLE: begin
                if (!(gnt0_q || gnt1_q)) begin
                    elig0_s = req0;
                    elig1_s = req1;
                end else begin
                    elig0_s = 1'b0;
                    elig1_s = 1'b0;
                end
            end
            ST_DONE: begin
                elig0_s    = req0 & req0_q;
                elig1_s    = req1 & req1_q;
                arb_last_s = owner_q;
            end
            default: begin
                elig0_s = 1'b0;
                elig1_s = 1'b0;
            end
        endcase
        win_s = arb_pick(elig0_s, elig1_s, arb_last_s);
        any_s = elig0_s | elig1_s;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        owner_d = owner_q;
        last_d  = last_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_q || gnt1_q) begin
                    // Grant cycle: operands are stable on this closing edge.
                    state_d = ST_RUN;
                    if (owner_q == ID1) begin
                        a_d     = a1;
                        b_d     = b1;
                        carry_d = cin1;
                    end else begin
                        a_d     = a0;
                        b_d     = b0;
                        carry_d = cin0;
                    end
                    res_d = '0;
                    cnt_d = '0;
                end else if (any_s) begin
                    gnt0_d  = (win_s == ID0);
                    gnt1_d  = (win_s == ID1);
                    owner_d = win_s;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                carry_d = fa_co_s;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = res_ext_s[WIDTH-1:1];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Result is loaded on entry to DONE so it is valid with done.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sum_d   = res_ext_s;
                    cout_d  = fa_co_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
                if (any_s) begin
                    gnt0_d  = (win_s == ID0);
                    gnt1_d  = (win_s == ID1);
                    owner_d = win_s;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= ID0;
            last_q  <= ID1;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            req0_q  <= 1'b0;
            req1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            req0_q  <= req0;
            req1_q  <= req1;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
module tb_serial_add_arbiter;

    localparam int W = 8;

    typedef struct packed {
        logic         owner;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         cin0 = 1'b0, cin1 = 1'b0;
    logic         gnt0, gnt1, busy, owner, done, cout;
    logic [W-1:0] sum;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    int   gnt_ids[$];
    int   gnt_cycs[$];

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .owner(owner),
        .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Grant watcher: logs every grant with its cycle.
    always @(negedge clk) begin
        if (!rst && (gnt0 || gnt1)) begin
            check("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
            gnt_ids.push_back(gnt1 ? 1 : 0);
            gnt_cycs.push_back(cyc);
            last_gnt_cyc = cyc;
        end
    end

    // Scoreboard monitor: compares each done against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            check("done_latency", cyc - last_gnt_cyc, W + 1);
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("owner", {31'd0, owner}, {31'd0, e.owner});
                check("sum", {24'd0, sum}, {24'd0, e.sum});
                check("cout", {31'd0, cout}, {31'd0, e.cout});
            end
        end
    end

    task automatic wait_done(input int target);
        for (int k = 0; k < 80 && done_cnt < target; k++) tick();
        check("done_seen", {31'd0, done_cnt >= target}, 32'd1);
    endtask

    task automatic do_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es, input logic ec,
                          input bit chk_busy);
        int n0;
        int dn0;
        bit got;
        n0  = gnt_ids.size();
        dn0 = done_cnt;
        if (id == 0) begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (gnt_ids.size() > n0) got = 1'b1;
        end
        check("gnt_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("gnt_id", gnt_ids[n0], id);
            exp_q.push_back('{owner: id[0], sum: es, cout: ec});
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (got && chk_busy) begin
            for (int k = 0; k <= W + 1; k++) begin
                check("busy_high", {31'd0, busy}, 32'd1);
                check("done_pulse", {31'd0, done}, {31'd0, k == W + 1});
                tick();
            end
            check("busy_low_after", {31'd0, busy}, 32'd0);
        end
        wait_done(dn0 + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dn0;
        int fair_ids[4] = '{0, 1, 0, 1};
        bit got;

        // Reset values
        tick();
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        // Fairness: first tie goes to 0, then strict alternation
        base = gnt_ids.size();
        dn0  = done_cnt;
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;   // 0x046
        a1 = 8'hA0; b1 = 8'h70; cin1 = 1'b1;   // 0x111
        exp_q.push_back('{owner: 1'b0, sum: 8'h46, cout: 1'b0});
        exp_q.push_back('{owner: 1'b1, sum: 8'h11, cout: 1'b1});
        exp_q.push_back('{owner: 1'b0, sum: 8'h46, cout: 1'b0});
        exp_q.push_back('{owner: 1'b1, sum: 8'h11, cout: 1'b1});
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 80 && gnt_ids.size() < base + 4; k++) tick();
        req0 = 1'b0;
        req1 = 1'b0;
        check("fair_gnt_count", gnt_ids.size() - base, 4);
        if (gnt_ids.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("fair_order", gnt_ids[base + i], fair_ids[i]);
            for (int i = 1; i < 4; i++)
                check("fair_spacing", gnt_cycs[base + i] - gnt_cycs[base + i - 1], W + 2);
        end
        wait_done(dn0 + 4);
        tick();

        // Basic add on requester 0 with busy/done timing
        do_add(0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b1);
        tick();

        // Overflow cases on requester 1
        do_add(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        check("hold_sum", {24'd0, sum}, 32'h00);
        do_add(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        check("hold_sum_idle", {24'd0, sum}, 32'hFF);

        // Late request: req1 raised during requester 0's RUN
        base = gnt_ids.size();
        dn0  = done_cnt;
        req0 = 1'b1; a0 = 8'h80; b0 = 8'h80; cin0 = 1'b1;   // 0x101
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (gnt_ids.size() > base) got = 1'b1;
        end
        check("late_gnt0_seen", {31'd0, got}, 32'd1);
        exp_q.push_back('{owner: 1'b0, sum: 8'h01, cout: 1'b1});
        exp_q.push_back('{owner: 1'b1, sum: 8'h7F, cout: 1'b0});
        req0 = 1'b0;
        tick();
        tick();
        tick();
        req1 = 1'b1; a1 = 8'h55; b1 = 8'h2A; cin1 = 1'b0;   // 0x07F
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (done) got = 1'b1;
            else check("late_no_early_gnt1", {31'd0, gnt1}, 32'd0);
        end
        check("late_done_seen", {31'd0, got}, 32'd1);
        tick();
        check("late_gnt1_after_done", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        wait_done(dn0 + 2);
        tick();

        // Reset during RUN bit 4
        base = gnt_ids.size();
        req1 = 1'b1; a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (gnt_ids.size() > base) got = 1'b1;
        end
        check("abort_gnt1_seen", {31'd0, got}, 32'd1);
        req1 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_owner", {31'd0, owner}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        dn0 = done_cnt;
        for (int k = 0; k < 15; k++) tick();
        check("abort_no_done", done_cnt - dn0, 0);
        check("abort_sum_after", {24'd0, sum}, 32'd0);

        do_add(1, 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
